alu_share_arbiter: RTL and testbench

//  Shares one combinational ALU_TOP instance between two requesters: req 0 = pipeline EX stage,
//  req 1 = auxiliary unit (address/CSR helper). Round-robin arbitration, registered ALU

---
 rtl/alu_share_arbiter.sv | 157 +++++++++++++++
 tb/tb_alu_share_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one combinational ALU_TOP between two requesters (0 = pipeline EX
//   stage, 1 = auxiliary address/CSR helper). Arbitration is round-robin. The
//   ALU operands are registered. Results come back on one tagged response
//   channel that is held under valid/ready back-pressure.
//
//   Ports
//     CLK, RST_N               clock, asynchronous active-low reset
//     REQx_VALID / REQx_BUS    request x: {PC,RS1,RS2,IMM,OPCODE,FUNCT3,FUNCT7}
//     REQx_READY               request x accepted this cycle (combinational)
//     ALU_PC..ALU_FUNCT7       registered operands driven to ALU_TOP
//     ALU_OUT                  combinational result from ALU_TOP
//     RSP_VALID/ID/DATA        registered response, owner tag and result
//     RSP_READY                response consumer accepts
//     BUSY                     arbiter not idle
module alu_share_arbiter #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned OPCODE_WIDTH = 7,
  parameter int unsigned BUS_WIDTH    = 4*DATA_WIDTH+OPCODE_WIDTH+10
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    REQ0_VALID,
  input  logic [BUS_WIDTH-1:0]    REQ0_BUS,
  output logic                    REQ0_READY,
  input  logic                    REQ1_VALID,
  input  logic [BUS_WIDTH-1:0]    REQ1_BUS,
  output logic                    REQ1_READY,
  output logic [DATA_WIDTH-1:0]   ALU_PC,
  output logic [DATA_WIDTH-1:0]   ALU_RS1,
  output logic [DATA_WIDTH-1:0]   ALU_RS2,
  output logic [DATA_WIDTH-1:0]   ALU_IMM,
  output logic [OPCODE_WIDTH-1:0] ALU_OPCODE,
  output logic [2:0]              ALU_FUNCT3,
  output logic [6:0]              ALU_FUNCT7,
  input  logic [DATA_WIDTH-1:0]   ALU_OUT,
  output logic                    RSP_VALID,
  output logic                    RSP_ID,
  output logic [DATA_WIDTH-1:0]   RSP_DATA,
  input  logic                    RSP_READY,
  output logic                    BUSY
);

  localparam int unsigned OPC_LSB = 10;
  localparam int unsigned IMM_LSB = OPC_LSB + OPCODE_WIDTH;
  localparam int unsigned RS2_LSB = IMM_LSB + DATA_WIDTH;
  localparam int unsigned RS1_LSB = RS2_LSB + DATA_WIDTH;
  localparam int unsigned PC_LSB  = RS1_LSB + DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic                 rr_ptr;
  logic                 owner;
  logic                 grant_win;
  logic                 winner;
  logic                 accept;
  logic [BUS_WIDTH-1:0] win_bus;

  always_comb begin
    grant_win  = 1'b0;
    winner     = 1'b0;
    REQ0_READY = 1'b0;
    REQ1_READY = 1'b0;
    accept     = 1'b0;
    win_bus    = REQ0_BUS;
    state_nxt  = IDLE;

    // RST_N gates the window so READY stays low while reset is held,
    // even though the state register already reads IDLE.
    grant_win = RST_N & ((state == IDLE) | ((state == RESP) & RSP_READY));

    if (REQ0_VALID & REQ1_VALID)
      winner = rr_ptr;
    else
      winner = REQ1_VALID;

    REQ0_READY = grant_win & REQ0_VALID & ~winner;
    REQ1_READY = grant_win & REQ1_VALID & winner;
    accept     = REQ0_READY | REQ1_READY;
    win_bus    = winner ? REQ1_BUS : REQ0_BUS;

    case (state)
      IDLE:    state_nxt = accept ? EXEC : IDLE;
      EXEC:    state_nxt = RESP;
      RESP: begin
        if (RSP_READY)
          state_nxt = accept ? EXEC : IDLE;
        else
          state_nxt = RESP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rr_ptr     <= 1'b0;
      owner      <= 1'b0;
      ALU_PC     <= '0;
      ALU_RS1    <= '0;
      ALU_RS2    <= '0;
      ALU_IMM    <= '0;
      ALU_OPCODE <= '0;
      ALU_FUNCT3 <= '0;
      ALU_FUNCT7 <= '0;
    end else if (accept) begin
      rr_ptr     <= ~winner;
      owner      <= winner;
      ALU_PC     <= win_bus[PC_LSB  +: DATA_WIDTH];
      ALU_RS1    <= win_bus[RS1_LSB +: DATA_WIDTH];
      ALU_RS2    <= win_bus[RS2_LSB +: DATA_WIDTH];
      ALU_IMM    <= win_bus[IMM_LSB +: DATA_WIDTH];
      ALU_OPCODE <= win_bus[OPC_LSB +: OPCODE_WIDTH];
      ALU_FUNCT3 <= win_bus[9:7];
      ALU_FUNCT7 <= win_bus[6:0];
    end
  end

  // ID and DATA keep their last value after a response is consumed; only
  // VALID drops. Any non-EXEC/RESP state (including illegal ones) clears VALID.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      RSP_VALID <= 1'b0;
      RSP_ID    <= 1'b0;
      RSP_DATA  <= '0;
    end else begin
      case (state)
        EXEC: begin
          RSP_VALID <= 1'b1;
          RSP_ID    <= owner;
          RSP_DATA  <= ALU_OUT;
        end
        RESP: begin
          if (RSP_READY)
            RSP_VALID <= 1'b0;
        end
        default: RSP_VALID <= 1'b0;
      endcase
    end
  end

  assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned OW = 7;
  localparam int unsigned BW = 4*DW+OW+10;

  logic          CLK;
  logic          RST_N;
  logic          v0, v1, r0, r1;
  logic [BW-1:0] b0, b1;
  logic [DW-1:0] alu_pc, alu_rs1, alu_rs2, alu_imm, alu_out, rsp_data;
  logic [OW-1:0] alu_op;
  logic [2:0]    alu_f3;
  logic [6:0]    alu_f7;
  logic          rsp_valid, rsp_id, rsp_ready, busy;

  int unsigned total;
  int unsigned bad;

  // reference model state: transaction level
  logic          m_rr;
  logic          m_if_v;
  logic          m_if_id;
  logic [DW-1:0] m_if_data;
  logic          m_rv;
  logic          m_rid;
  logic [DW-1:0] m_rdata;
  logic [BW-1:0] m_last;
  logic          e0, e1;

  alu_share_arbiter #(.DATA_WIDTH(DW), .OPCODE_WIDTH(OW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ0_VALID(v0), .REQ0_BUS(b0), .REQ0_READY(r0),
    .REQ1_VALID(v1), .REQ1_BUS(b1), .REQ1_READY(r1),
    .ALU_PC(alu_pc), .ALU_RS1(alu_rs1), .ALU_RS2(alu_rs2), .ALU_IMM(alu_imm),
    .ALU_OPCODE(alu_op), .ALU_FUNCT3(alu_f3), .ALU_FUNCT7(alu_f7),
    .ALU_OUT(alu_out),
    .RSP_VALID(rsp_valid), .RSP_ID(rsp_id), .RSP_DATA(rsp_data),
    .RSP_READY(rsp_ready), .BUSY(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [BW-1:0] mk_bus(input logic [DW-1:0] pc, input logic [DW-1:0] rs1,
                                           input logic [DW-1:0] rs2, input logic [DW-1:0] imm,
                                           input logic [OW-1:0] op, input logic [2:0] f3,
                                           input logic [6:0] f7);
    return {pc, rs1, rs2, imm, op, f3, f7};
  endfunction

  // Stand-in for ALU_TOP: a small RISC-V-flavoured subset.
  function automatic logic [DW-1:0] alu_fn(input logic [BW-1:0] b);
    logic [DW-1:0] pc, rs1, rs2, imm;
    logic [OW-1:0] op;
    logic [2:0]    f3;
    logic [6:0]    f7;
    {pc, rs1, rs2, imm, op, f3, f7} = b;
    if (op == 7'b0110011) begin
      case (f3)
        3'd4:    return rs1 ^ rs2;
        3'd6:    return rs1 | rs2;
        3'd7:    return rs1 & rs2;
        default: return f7[5] ? rs1 - rs2 : rs1 + rs2;
      endcase
    end else if (op == 7'b0010011) begin
      return rs1 + imm;
    end
    return pc + imm;
  endfunction

  assign alu_out = alu_fn({alu_pc, alu_rs1, alu_rs2, alu_imm, alu_op, alu_f3, alu_f7});

  function automatic logic [BW-1:0] rand_bus();
    logic [OW-1:0] op;
    logic [6:0]    f7;
    case ($urandom_range(2))
      0:       op = 7'b0110011;
      1:       op = 7'b0010011;
      default: op = OW'($urandom);
    endcase
    f7 = ($urandom_range(1) == 1) ? 7'b0100000 : 7'b0000000;
    return mk_bus($urandom, $urandom, $urandom, $urandom, op, 3'($urandom), f7);
  endfunction

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_if_v = 0; m_if_id = 0; m_if_data = '0;
    m_rv = 0; m_rid = 0; m_rdata = '0; m_last = '0;
  endtask

  // One clock: compare DUT against model at the negedge, advance model after posedge.
  task automatic cycle();
    logic win, who;
    logic [BW-1:0] lb;
    @(negedge CLK);
    win = RST_N && !m_if_v && (!m_rv || rsp_ready);
    who = (v0 && v1) ? m_rr : v1;
    e0  = win && v0 && !who;
    e1  = win && v1 && who;
    lb  = m_last;
    check_val("req0_ready", r0, e0);
    check_val("req1_ready", r1, e1);
    check_val("rsp_valid", rsp_valid, m_rv);
    check_val("rsp_id", rsp_id, m_rid);
    check_val("rsp_data", rsp_data, m_rdata);
    check_val("busy", busy, m_if_v || m_rv);
    check_val("alu_pc", alu_pc, lb[BW-1 -: DW]);
    check_val("alu_rs1", alu_rs1, lb[BW-DW-1 -: DW]);
    check_val("alu_rs2", alu_rs2, lb[BW-2*DW-1 -: DW]);
    check_val("alu_imm", alu_imm, lb[BW-3*DW-1 -: DW]);
    check_val("alu_ctl", {alu_op, alu_f3, alu_f7}, lb[OW+9:0]);
    @(posedge CLK);
    #1;
    if (!RST_N) begin
      model_reset();
    end else begin
      if (m_if_v) begin
        m_rv = 1; m_rid = m_if_id; m_rdata = m_if_data; m_if_v = 0;
      end else if (m_rv && rsp_ready) begin
        m_rv = 0;
      end
      if (e0 || e1) begin
        m_last    = e1 ? b1 : b0;
        m_if_v    = 1;
        m_if_id   = e1;
        m_if_data = alu_fn(m_last);
        m_rr      = ~e1;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0;
    model_reset();
    RST_N = 0; v0 = 1; v1 = 1; rsp_ready = 0;
    b0 = rand_bus(); b1 = rand_bus();

    // reset with both requesters asking
    cycle(); cycle();
    check_val("rst_ready", {r0, r1}, 2'b00);
    RST_N = 1; v0 = 0; v1 = 0;
    cycle();

    // single ADD from requester 0
    v0 = 1; b0 = mk_bus(32'h100, 32'd5, 32'd7, 32'd0, 7'b0110011, 3'd0, 7'd0);
    rsp_ready = 1;
    cycle();
    check_val("add_alu_rs1", alu_rs1, 32'd5);
    v0 = 0;
    cycle();
    check_val("add_rsp_valid", rsp_valid, 1'b1);
    check_val("add_rsp_id", rsp_id, 1'b0);
    check_val("add_rsp_data", rsp_data, 32'd12);
    cycle();

    // both requesters continuously, consumer always ready
    v0 = 1; v1 = 1; b0 = rand_bus(); b1 = rand_bus();
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (e0) b0 = rand_bus();
      if (e1) b1 = rand_bus();
    end
    v0 = 0; v1 = 0;
    cycle(); cycle(); cycle();

    // SUB from requester 1 under back-pressure
    rsp_ready = 0;
    v1 = 1; b1 = mk_bus(32'h0, 32'd3, 32'd10, 32'd0, 7'b0110011, 3'd0, 7'b0100000);
    cycle();
    v1 = 0;
    cycle();
    v0 = 1; v1 = 1; b0 = rand_bus(); b1 = rand_bus();
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_val("sub_hold_data", rsp_data, 32'hFFFF_FFF9);
      check_val("sub_hold_id", rsp_id, 1'b1);
    end
    rsp_ready = 1;
    cycle();
    check_val("release_gnt0_rs1", alu_rs1, b0[BW-DW-1 -: DW]);
    v0 = 0; v1 = 0;
    cycle(); cycle(); cycle();

    // asynchronous reset while an op is in EXEC
    v0 = 1; b0 = rand_bus(); v1 = 0;
    cycle();
    #2 RST_N = 0;
    #1;
    check_val("async_busy", busy, 1'b0);
    check_val("async_rsp_valid", rsp_valid, 1'b0);
    check_val("async_ready", {r0, r1}, 2'b00);
    check_val("async_alu_rs1", alu_rs1, 32'd0);
    model_reset();
    cycle(); cycle();
    RST_N = 1;
    v0 = 1; v1 = 1; b0 = rand_bus(); b1 = rand_bus();
    cycle();
    v0 = 0; v1 = 0;
    cycle(); cycle(); cycle();

    // requester 1 alone, then both: pointer now favours 0
    v1 = 1; b1 = rand_bus();
    cycle();
    v1 = 0;
    cycle();
    v0 = 1; v1 = 1; b0 = rand_bus(); b1 = rand_bus();
    cycle();
    check_val("after_req1_gnt0", alu_rs1, b0[BW-DW-1 -: DW]);
    v0 = 0; v1 = 0;
    cycle(); cycle();

    // randomized traffic with withdrawals and back-pressure
    for (int i = 0; i < 400; i++) begin
      cycle();
      if (e0 || !v0) begin
        v0 = ($urandom_range(2) != 0);
        b0 = rand_bus();
      end else if ($urandom_range(11) == 0) begin
        v0 = 0;
      end
      if (e1 || !v1) begin
        v1 = ($urandom_range(2) != 0);
        b1 = rand_bus();
      end else if ($urandom_range(11) == 0) begin
        v1 = 0;
      end
      rsp_ready = ($urandom_range(3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
